// File: rtl/dm_mmio_pkg.sv
// Shared definitions for the data-side MMIO bridge: register word offsets,
// timer control bit positions and the timer control struct.
package dm_mmio_pkg;

  // Word offsets (byte address bits [7:2]) inside the MMIO window
  localparam logic [5:0] CYCLE_LO   = 6'h00;
  localparam logic [5:0] CYCLE_HI   = 6'h01;
  localparam logic [5:0] TIMER_LOAD = 6'h02;
  localparam logic [5:0] TIMER_CTRL = 6'h03;
  localparam logic [5:0] TIMER_STAT = 6'h04;
  localparam logic [5:0] GPIO_OUT   = 6'h05;
  localparam logic [5:0] GPIO_IN    = 6'h06;
  localparam logic [5:0] TIMER_VAL  = 6'h07;

  // TIMER_CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_PERIODIC = 2;

  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } timer_ctrl_t;

  function automatic timer_ctrl_t ctrl_from_word(logic [31:0] w);
    timer_ctrl_t c;
    c.en       = w[CTRL_EN];
    c.ie       = w[CTRL_IE];
    c.periodic = w[CTRL_PERIODIC];
    return c;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer: LOAD/CTRL/VAL registers, sticky pending flag with
// write-1-to-clear, and a registered level interrupt.
module mmio_timer
  import dm_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_we,
  input  logic        ctrl_we,
  input  logic        stat_we,
  input  logic [31:0] wdata,
  output logic [31:0] load_o,
  output logic [2:0]  ctrl_o,
  output logic [31:0] val_o,
  output logic        pending_o,
  output logic        irq_o
);

  timer_ctrl_t ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] val_q, val_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  timer_ctrl_t ctrl_wr;

  // Count/expiry first, then register writes; a CTRL write overrides the
  // expiry's en update, while an expiry overrides a same-cycle W1C.
  always_comb begin
    load_d  = load_we ? wdata : load_q;
    ctrl_d  = ctrl_q;
    val_d   = val_q;
    pend_d  = pend_q;
    ctrl_wr = ctrl_from_word(wdata);

    if (stat_we && wdata[0]) pend_d = 1'b0;

    if (ctrl_q.en) begin
      if (val_q != '0) begin
        val_d = val_q - 32'd1;
      end else begin
        pend_d = 1'b1;
        if (ctrl_q.periodic) val_d = load_q;
        else                 ctrl_d.en = 1'b0;
      end
    end

    if (ctrl_we) begin
      ctrl_d = ctrl_wr;
      if (ctrl_wr.en && !ctrl_q.en) val_d = load_q;
    end

    irq_d = pend_q & ctrl_q.ie;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      load_q <= '0;
      val_q  <= '0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      load_q <= load_d;
      val_q  <= val_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign load_o    = load_q;
  assign ctrl_o    = ctrl_q;
  assign val_o     = val_q;
  assign pending_o = pend_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/dm_mmio_bridge.sv
// Data-side address decoder: claims the 256-byte MMIO window for the local
// cycle counter, timer and GPIO, passes everything else to the SRAM, and
// returns read data with the same one-cycle latency as the SRAM.
module dm_mmio_bridge
  import dm_mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_dm_enable,
  input  logic              cpu_dm_write,
  input  logic [31:0]       cpu_dm_address,
  input  logic [31:0]       cpu_dm_in,
  output logic [31:0]       cpu_dm_out,
  output logic              sram_enable,
  output logic              sram_write,
  output logic [31:0]       sram_address,
  output logic [31:0]       sram_in,
  input  logic [31:0]       sram_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n;
  logic              mmio_hit, mmio_rd, mmio_wr;
  logic [5:0]        reg_off;
  logic [63:0]       cycle_q, cycle_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s1_d, gpio_s2_q, gpio_s2_d;
  logic [31:0]       mmio_rdata_q, mmio_rdata_d;
  logic              last_mmio_rd_q, last_mmio_rd_d;
  logic              last_sram_rd_q, last_sram_rd_d;
  logic [31:0]       t_load, t_val;
  logic [2:0]        t_ctrl;
  logic              t_pend;
  logic [1:0]        unused_addr_bits;

  // Release of rst is retimed to clk; assertion stays asynchronous
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Reset synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n            = rst_sync_q[1];
  assign unused_addr_bits = cpu_dm_address[1:0];

  // Window decode
  always_comb begin
    mmio_hit = cpu_dm_enable && (cpu_dm_address[31:8] == MMIO_BASE[31:8]);
    mmio_rd  = mmio_hit && !cpu_dm_write;
    mmio_wr  = mmio_hit && cpu_dm_write;
    reg_off  = cpu_dm_address[7:2];
  end

  assign sram_enable  = cpu_dm_enable & ~mmio_hit;
  assign sram_write   = cpu_dm_write & sram_enable;
  assign sram_address = cpu_dm_address;
  assign sram_in      = cpu_dm_in;

  mmio_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_we   (mmio_wr && reg_off == TIMER_LOAD),
    .ctrl_we   (mmio_wr && reg_off == TIMER_CTRL),
    .stat_we   (mmio_wr && reg_off == TIMER_STAT),
    .wdata     (cpu_dm_in),
    .load_o    (t_load),
    .ctrl_o    (t_ctrl),
    .val_o     (t_val),
    .pending_o (t_pend),
    .irq_o     (timer_irq)
  );

  // Cycle counter, HI shadow, GPIO, and read-data capture at the request edge
  always_comb begin
    cycle_d        = cycle_q + 64'd1;
    shadow_d       = shadow_q;
    gpio_out_d     = gpio_out_q;
    gpio_s1_d      = gpio_in;
    gpio_s2_d      = gpio_s1_q;
    mmio_rdata_d   = '0;
    last_mmio_rd_d = mmio_rd;
    last_sram_rd_d = sram_enable && !cpu_dm_write;

    if (mmio_rd && reg_off == CYCLE_LO) shadow_d = cycle_q[63:32];
    if (mmio_wr && reg_off == GPIO_OUT) gpio_out_d = cpu_dm_in[GPIO_W-1:0];

    if (mmio_rd) begin
      case (reg_off)
        CYCLE_LO:   mmio_rdata_d = cycle_q[31:0];
        CYCLE_HI:   mmio_rdata_d = shadow_q;
        TIMER_LOAD: mmio_rdata_d = t_load;
        TIMER_CTRL: mmio_rdata_d = 32'(t_ctrl);
        TIMER_STAT: mmio_rdata_d = 32'(t_pend);
        GPIO_OUT:   mmio_rdata_d = 32'(gpio_out_q);
        GPIO_IN:    mmio_rdata_d = 32'(gpio_s2_q);
        TIMER_VAL:  mmio_rdata_d = t_val;
        default:    mmio_rdata_d = '0;
      endcase
    end
  end

  // Bridge-level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q        <= '0;
      shadow_q       <= '0;
      gpio_out_q     <= '0;
      gpio_s1_q      <= '0;
      gpio_s2_q      <= '0;
      mmio_rdata_q   <= '0;
      last_mmio_rd_q <= 1'b0;
      last_sram_rd_q <= 1'b0;
    end else begin
      cycle_q        <= cycle_d;
      shadow_q       <= shadow_d;
      gpio_out_q     <= gpio_out_d;
      gpio_s1_q      <= gpio_s1_d;
      gpio_s2_q      <= gpio_s2_d;
      mmio_rdata_q   <= mmio_rdata_d;
      last_mmio_rd_q <= last_mmio_rd_d;
      last_sram_rd_q <= last_sram_rd_d;
    end
  end

  assign gpio_out   = gpio_out_q;
  assign cpu_dm_out = last_mmio_rd_q ? mmio_rdata_q :
                      last_sram_rd_q ? sram_out : 32'd0;

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Bench for dm_mmio_bridge: directed scenarios plus randomized traffic,
// checked every cycle against a register-level reference model.
module tb_dm_mmio_bridge;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          GPIO_W = 8;
  localparam int K_NONE = 0, K_SRAM = 1, K_MMIO = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_dm_enable = 1'b0;
  logic              cpu_dm_write = 1'b0;
  logic [31:0]       cpu_dm_address = '0;
  logic [31:0]       cpu_dm_in = '0;
  logic [31:0]       cpu_dm_out;
  logic              sram_enable, sram_write;
  logic [31:0]       sram_address, sram_in;
  logic [31:0]       sram_out = '0;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  dm_mmio_bridge #(.MMIO_BASE(BASE), .GPIO_W(GPIO_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_dm_enable  (cpu_dm_enable),
    .cpu_dm_write   (cpu_dm_write),
    .cpu_dm_address (cpu_dm_address),
    .cpu_dm_in      (cpu_dm_in),
    .cpu_dm_out     (cpu_dm_out),
    .sram_enable    (sram_enable),
    .sram_write     (sram_write),
    .sram_address   (sram_address),
    .sram_in        (sram_in),
    .sram_out       (sram_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .timer_irq      (timer_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0]       m_cycle;
  logic [31:0]       m_shadow, m_load, m_val, prev_rdata;
  logic              m_en, m_ie, m_per, m_pend, m_irq;
  logic [GPIO_W-1:0] m_gpio_out, m_s1, m_s2;
  int                prev_kind;

  logic [31:0] obs_out;
  logic        obs_sram_en;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = '0; m_shadow = '0; m_load = '0; m_val = '0;
    m_en = 0; m_ie = 0; m_per = 0; m_pend = 0; m_irq = 0;
    m_gpio_out = '0; m_s1 = '0; m_s2 = '0;
    prev_kind = K_NONE; prev_rdata = '0;
  endtask

  // One clock edge of the register map as described by its rules
  task automatic model_step(input logic en, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic hit, rd, wrm, expired, w1c;
    logic [5:0] off;
    logic [31:0] rv, n_val;
    logic n_en, n_ie, n_per;
    hit = en && (addr[31:8] == BASE[31:8]);
    off = addr[7:2];
    rd  = hit && !wr;
    wrm = hit && wr;
    rv  = '0;
    if (rd) begin
      case (off)
        6'd0: rv = m_cycle[31:0];
        6'd1: rv = m_shadow;
        6'd2: rv = m_load;
        6'd3: rv = {29'd0, m_per, m_ie, m_en};
        6'd4: rv = {31'd0, m_pend};
        6'd5: rv = 32'(m_gpio_out);
        6'd6: rv = 32'(m_s2);
        6'd7: rv = m_val;
        default: rv = '0;
      endcase
    end
    expired = m_en && (m_val == 32'd0);
    w1c     = wrm && (off == 6'd4) && wd[0];
    n_en = m_en; n_ie = m_ie; n_per = m_per; n_val = m_val;
    if (m_en && !expired) n_val = m_val - 32'd1;
    if (expired) begin
      if (m_per) n_val = m_load;
      else       n_en = 1'b0;
    end
    if (wrm && off == 6'd3) begin
      n_en = wd[0]; n_ie = wd[1]; n_per = wd[2];
      if (wd[0] && !m_en) n_val = m_load;
    end
    m_irq  = m_pend && m_ie;
    m_pend = expired ? 1'b1 : (w1c ? 1'b0 : m_pend);
    if (wrm && off == 6'd2) m_load = wd;
    m_en = n_en; m_ie = n_ie; m_per = n_per; m_val = n_val;
    if (rd && off == 6'd0) m_shadow = m_cycle[63:32];
    if (wrm && off == 6'd5) m_gpio_out = wd[GPIO_W-1:0];
    m_s2 = m_s1;
    m_s1 = gpio_in;
    m_cycle = m_cycle + 64'd1;
    prev_kind  = rd ? K_MMIO : ((en && !hit && !wr) ? K_SRAM : K_NONE);
    prev_rdata = rv;
  endtask

  // One bus cycle, entered just after a falling edge
  task automatic do_cycle(input logic en, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] sv);
    logic hit;
    logic [31:0] exp_out;
    cpu_dm_enable = en; cpu_dm_write = wr; cpu_dm_address = addr;
    cpu_dm_in = wd; sram_out = sv;
    if ($urandom_range(0, 3) == 0) gpio_in = GPIO_W'($urandom);
    #1;
    hit = en && (addr[31:8] == BASE[31:8]);
    check_val("sram_enable", sram_enable, en && !hit);
    check_val("sram_write", sram_write, en && !hit && wr);
    check_val("sram_address", sram_address, addr);
    check_val("sram_in", sram_in, wd);
    exp_out = (prev_kind == K_MMIO) ? prev_rdata : ((prev_kind == K_SRAM) ? sv : 32'd0);
    obs_out = cpu_dm_out;
    obs_sram_en = sram_enable;
    check_val("cpu_dm_out", cpu_dm_out, exp_out);
    @(posedge clk);
    model_step(en, wr, addr, wd);
    @(negedge clk);
    check_val("gpio_out", gpio_out, m_gpio_out);
    check_val("timer_irq", timer_irq, m_irq);
  endtask

  task automatic do_reset();
    cpu_dm_enable = 0; cpu_dm_write = 0; cpu_dm_address = '0; cpu_dm_in = '0;
    rst = 1'b0;
    #1;
    check_val("rst_cpu_dm_out", cpu_dm_out, 0);
    check_val("rst_gpio_out", gpio_out, 0);
    check_val("rst_timer_irq", timer_irq, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 32'h0, 32'h0, $urandom);
  endtask

  logic [31:0] r_addr, r_data;
  logic        r_en, r_wr;

  initial begin
    model_reset();
    #2;
    do_reset();

    // SRAM read passes through with one-cycle latency
    do_cycle(1, 0, 32'h0000_0040, 32'h0, $urandom);
    check_val("sram_rd_enable", obs_sram_en, 1);
    do_cycle(0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    check_val("sram_rd_data", obs_out, 32'hDEAD_BEEF);

    // GPIO write and read-back
    do_cycle(1, 1, BASE + 32'h14, 32'hA5, $urandom);
    check_val("gpio_wr_no_sram", obs_sram_en, 0);
    check_val("gpio_out_a5", gpio_out, 8'hA5);
    do_cycle(1, 0, BASE + 32'h14, 32'h0, $urandom);
    idle(1);
    check_val("gpio_readback", obs_out, 32'hA5);

    // One-shot timer: LOAD=3, CTRL=en|ie
    do_cycle(1, 1, BASE + 32'h08, 32'd3, $urandom);
    do_cycle(1, 1, BASE + 32'h0C, 32'h3, $urandom);
    do_cycle(1, 0, BASE + 32'h1C, 32'h0, $urandom);
    for (int k = 3; k >= 1; k--) begin
      do_cycle(1, 0, BASE + 32'h1C, 32'h0, $urandom);
      check_val("oneshot_val", obs_out, k);
    end
    check_val("oneshot_irq_not_yet", timer_irq, 0);
    do_cycle(1, 0, BASE + 32'h0C, 32'h0, $urandom);
    check_val("oneshot_val0", obs_out, 0);
    check_val("oneshot_irq_up", timer_irq, 1);
    idle(1);
    check_val("oneshot_en_cleared", obs_out, 32'h2);
    do_cycle(1, 1, BASE + 32'h10, 32'h1, $urandom);
    check_val("w1c_irq_still", timer_irq, 1);
    idle(1);
    check_val("w1c_irq_drop", timer_irq, 0);

    // Periodic timer: LOAD=2, CTRL=7, expiry every 3 cycles
    do_cycle(1, 1, BASE + 32'h08, 32'd2, $urandom);
    do_cycle(1, 1, BASE + 32'h0C, 32'h7, $urandom);
    idle(3);
    do_cycle(1, 1, BASE + 32'h10, 32'h1, $urandom);
    do_cycle(1, 0, BASE + 32'h10, 32'h0, $urandom);
    do_cycle(1, 1, BASE + 32'h10, 32'h1, $urandom);
    check_val("periodic_cleared", obs_out, 0);
    do_cycle(1, 0, BASE + 32'h10, 32'h0, $urandom);
    idle(1);
    check_val("periodic_set_wins", obs_out, 1);

    // CYCLE shadow coherence across the low-word wrap
    force dut.cycle_q = 64'h0000_0007_FFFF_FFFA;
    #1;
    release dut.cycle_q;
    m_cycle = 64'h0000_0007_FFFF_FFFA;
    do_cycle(1, 0, BASE + 32'h00, 32'h0, $urandom);
    idle(1);
    check_val("cycle_lo", obs_out, 32'hFFFF_FFFA);
    idle(8);
    do_cycle(1, 0, BASE + 32'h04, 32'h0, $urandom);
    idle(1);
    check_val("cycle_hi_shadow", obs_out, 32'h7);
    do_cycle(1, 0, BASE + 32'h00, 32'h0, $urandom);
    do_cycle(1, 0, BASE + 32'h04, 32'h0, $urandom);
    check_val("cycle_lo_wrapped", obs_out, 32'h6);
    idle(1);
    check_val("cycle_hi_wrapped", obs_out, 32'h8);

    // Reset mid-count with a read in flight
    do_cycle(1, 1, BASE + 32'h0C, 32'h0, $urandom);
    do_cycle(1, 1, BASE + 32'h08, 32'd1, $urandom);
    do_cycle(1, 1, BASE + 32'h0C, 32'h7, $urandom);
    idle(4);
    do_cycle(1, 1, BASE + 32'h08, 32'd1000, $urandom);
    idle(3);
    do_cycle(1, 0, BASE + 32'h1C, 32'h0, $urandom);
    check_val("pre_rst_irq", timer_irq, 1);
    check_val("pre_rst_gpio", gpio_out, 8'hA5);
    do_reset();
    do_cycle(1, 0, BASE + 32'h1C, 32'h0, $urandom);
    check_val("post_rst_out", obs_out, 0);
    do_cycle(1, 0, BASE + 32'h0C, 32'h0, $urandom);
    check_val("post_rst_val", obs_out, 0);
    idle(1);
    check_val("post_rst_ctrl", obs_out, 0);
    idle(1);
    check_val("post_rst_idle_out", obs_out, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: r_addr = $urandom;
        3:       r_addr = BASE + 32'h100 + ($urandom & 32'hFF);
        default: r_addr = BASE + 32'($urandom_range(0, 20)) * 32'd4 + 32'($urandom_range(0, 3));
      endcase
      r_data = $urandom;
      if (r_addr[31:8] == BASE[31:8] && r_addr[7:2] == 6'd2 && $urandom_range(0, 3) != 0)
        r_data = 32'($urandom_range(0, 6));
      r_en = ($urandom_range(0, 7) != 0);
      r_wr = ($urandom_range(0, 1) != 0);
      do_cycle(r_en, r_wr, r_addr, r_data, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
